// File: rtl/count_event_monitor.sv
// count_event_monitor
// Watches the up/down counter output, flags wrap-around and hysteresis
// threshold crossings, and queues one event record per cycle into a small
// first-word-fall-through FIFO drained over a valid/ready handshake.

module count_event_monitor #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] HI_TH = 8'hC0,
  parameter logic [WIDTH-1:0] LO_TH = 8'h40,
  parameter int               DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] qd,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             level,
  output logic             overflow
);

  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] MAX_VAL   = '1;
  localparam logic [WIDTH-1:0] ZERO_VAL  = '0;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } level_t;

  level_t           state_q;
  level_t           state_d;

  logic [WIDTH-1:0] prev;
  logic             prev_valid;

  logic [2:0]       code_mem  [DEPTH];
  logic [WIDTH-1:0] value_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic             wrap_up;
  logic             wrap_dn;
  logic             rise;
  logic             fall;
  logic [2:0]       code;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_push;
  logic             drop;

  // A wrap is only meaningful against a sample taken on the previous enabled cycle
  assign wrap_up = en && prev_valid && (prev == MAX_VAL)  && (qd == ZERO_VAL);
  assign wrap_dn = en && prev_valid && (prev == ZERO_VAL) && (qd == MAX_VAL);

  // Hysteresis next-state: only an enabled sample may move the level
  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (en) begin
      case (state_q)
        LOW: begin
          if (qd >= HI_TH) begin
            state_d = HIGH;
            rise    = 1'b1;
          end
        end
        HIGH: begin
          if (qd <= LO_TH) begin
            state_d = LOW;
            fall    = 1'b1;
          end
        end
        default: state_d = LOW;
      endcase
    end
  end

  // Fold the simultaneous conditions into a single event code; combined codes win
  always_comb begin
    code = 3'b000;
    if (wrap_up && fall)      code = 3'b101;
    else if (wrap_dn && rise) code = 3'b110;
    else if (wrap_up)         code = 3'b001;
    else if (wrap_dn)         code = 3'b010;
    else if (rise)            code = 3'b011;
    else if (fall)            code = 3'b100;
  end

  assign push      = (code != 3'b000);
  assign evt_valid = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign pop       = evt_valid && evt_ready;
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;

  assign evt_code  = evt_valid ? code_mem[rd_ptr]  : 3'b000;
  assign evt_value = evt_valid ? value_mem[rd_ptr] : ZERO_VAL;
  assign level     = (state_q == HIGH);

  // Level state register
  always_ff @(posedge clk) begin
    if (clear) state_q <= LOW;
    else       state_q <= state_d;
  end

  // Previous-sample tracking; any disabled cycle breaks wrap continuity
  always_ff @(posedge clk) begin
    if (clear) begin
      prev       <= ZERO_VAL;
      prev_valid <= 1'b0;
    end else if (en) begin
      prev       <= qd;
      prev_valid <= 1'b1;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      code_mem[wr_ptr]  <= code;
      value_mem[wr_ptr] <= qd;
    end
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor
// Directed vectors for the event monitor: a table of single-cycle vectors for
// level, hysteresis, wrap and enable-gap behaviour, then hand-written
// sequences for FIFO overflow, full push+pop and clear mid-stream.

module tb_count_event_monitor;

  logic       clk;
  logic       clear;
  logic       en;
  logic [7:0] qd;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic [7:0] evt_value;
  logic       level;
  logic       overflow;

  int total;
  int bad;

  typedef struct {
    logic       clr;
    logic       ena;
    logic [7:0] q;
    logic       rdy;
    logic       ev;
    logic [2:0] code;
    logic [7:0] val;
    logic       lvl;
    logic       ovf;
    logic       zero;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  count_event_monitor #(
    .WIDTH(8),
    .HI_TH(8'hC0),
    .LO_TH(8'h40),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .clear(clear),
    .en(en),
    .qd(qd),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_value(evt_value),
    .level(level),
    .overflow(overflow)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then let outputs settle just after the edge
  task automatic applyStimulus(input logic c, input logic e, input logic [7:0] q, input logic r);
    clear     = c;
    en        = e;
    qd        = q;
    evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic compareField(input string tag, input string field, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [2:0] c, input logic [7:0] v,
                             input logic lvl, input logic ovf, input logic zero);
    compareField(tag, "evt_valid", {7'b0, evt_valid}, {7'b0, ev});
    compareField(tag, "level",     {7'b0, level},     {7'b0, lvl});
    compareField(tag, "overflow",  {7'b0, overflow},  {7'b0, ovf});
    if (ev) begin
      compareField(tag, "evt_code",  {5'b0, evt_code}, {5'b0, c});
      compareField(tag, "evt_value", evt_value, v);
    end else if (zero) begin
      compareField(tag, "evt_code",  {5'b0, evt_code}, 8'h00);
      compareField(tag, "evt_value", evt_value, 8'h00);
    end
  endtask

  task automatic step(input string tag, input logic c, input logic e, input logic [7:0] q, input logic r,
                      input logic ev, input logic [2:0] code, input logic [7:0] v,
                      input logic lvl, input logic ovf, input logic zero);
    applyStimulus(c, e, q, r);
    checkOutput(tag, ev, code, v, lvl, ovf, zero);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    clear     = 1'b1;
    en        = 1'b0;
    qd        = 8'h00;
    evt_ready = 1'b0;

    //            clr   en    qd     rdy    ev    code    val    lvl   ovf   zero
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b100, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 3'b110, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'b011, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0};

    $display("[TB] table vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].ena, vecs[i].q, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].code, vecs[i].val,
                  vecs[i].lvl, vecs[i].ovf, vecs[i].zero);
    end

    // Overflow: level starts HIGH, ready held low, five crossings
    $display("[TB] overflow sequence");
    step("ovf_push1", 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b100, 8'h40, 1'b0, 1'b0, 1'b0);
    step("ovf_push2", 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b100, 8'h40, 1'b1, 1'b0, 1'b0);
    step("ovf_push3", 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b100, 8'h40, 1'b0, 1'b0, 1'b0);
    step("ovf_push4", 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b100, 8'h40, 1'b1, 1'b0, 1'b0);
    step("ovf_drop5", 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b100, 8'h40, 1'b0, 1'b1, 1'b0);
    step("ovf_hold",  1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 3'b100, 8'h40, 1'b0, 1'b1, 1'b0);
    step("ovf_pop1",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'b011, 8'hC0, 1'b0, 1'b1, 1'b0);
    step("ovf_pop2",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'b100, 8'h40, 1'b0, 1'b1, 1'b0);
    step("ovf_pop3",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'b011, 8'hC0, 1'b0, 1'b1, 1'b0);
    step("ovf_pop4",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0);
    step("ovf_stick", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0);

    // Clear returns everything to reset, including the sticky flag
    step("clr_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);

    // Fill to full, then push and pop in the same cycle
    $display("[TB] full push+pop sequence");
    step("full_p1",   1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b0, 1'b0);
    step("full_p2",   1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b0, 1'b0, 1'b0);
    step("full_p3",   1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b0, 1'b0);
    step("full_p4",   1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b0, 1'b0, 1'b0);
    step("full_pp",   1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 3'b100, 8'h40, 1'b1, 1'b0, 1'b0);
    step("full_pop",  1'b0, 1'b0, 8'hC0, 1'b1, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b0, 1'b0);
    step("full_refill", 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b0, 1'b0, 1'b0);
    step("full_drop", 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 3'b011, 8'hC0, 1'b1, 1'b1, 1'b0);
    step("clr_mid",   1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);
    step("post_clr",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream monitor for the 8-bit up/down counter. Samples the counter output `qd` every enabled cycle, detects wrap-around in either direction and threshold crossings with hysteresis, and queues one event record per cycle into a 4-entry FIFO. A consumer drains the FIFO over a valid/ready handshake.

## Interface
- `WIDTH`, 8: counter width; must match the counter's `qd`.
- `HI_TH`, 8'hC0: upper threshold; LOW→HIGH when sample ≥ `HI_TH`.
- `LO_TH`, 8'h40: lower threshold; HIGH→LOW when sample ≤ `LO_TH`. Requires `LO_TH < HI_TH`.
- `DEPTH`, 4: event FIFO depth (power of two).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable; `qd` is sampled only when high.
- `qd`  in  WIDTH  counter value.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event this cycle.
- `evt_code`  out  3  head event code.
- `evt_value`  out  WIDTH  `qd` sample that caused the head event.
- `level`  out  1  hysteresis state: 0 = LOW, 1 = HIGH.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- State: `prev` (WIDTH), `prev_valid`, `level` FSM, FIFO (storage, rd/wr pointers, count), `overflow`.
- Enabled cycle (`en`=1):
  - Evaluate `qd` against `prev`, then load `prev`←`qd` and set `prev_valid`←1.
- Wrap detection requires `prev_valid`=1:
  - WRAP_UP: `prev`=2^WIDTH−1 and `qd`=0.
  - WRAP_DN: `prev`=0 and `qd`=2^WIDTH−1.
  - Any other step, including non-unit jumps from `load`, is not a wrap.
- Level FSM (evaluated on every enabled sample, including the first):
  - LOW→HIGH when `qd` ≥ `HI_TH`.
  - HIGH→LOW when `qd` ≤ `LO_TH`.
  - Otherwise hold.
- Event codes (at most one push per cycle):
  - 3'b001: WRAP_UP alone.
  - 3'b010: WRAP_DN alone.
  - 3'b011: RISE (LOW→HIGH) alone.
  - 3'b100: FALL (HIGH→LOW) alone.
  - 3'b101: WRAP_UP together with FALL.
  - 3'b110: WRAP_DN together with RISE.
  - 3'b000 and 3'b111 are never produced.
- `en`=0:
  - No sampling; `prev_valid`←0; `level` holds.
  - FIFO still drains.
  - The first sample after re-enable cannot produce a wrap event.
- FIFO:
  - Push `{code, qd}` when an event occurs.
  - Pop when `evt_valid` && `evt_ready`.
  - Full with no pop: the event is dropped and `overflow`←1. `overflow` is cleared only by `clear`.
  - Full with a simultaneous pop and push: both occur; the count is unchanged and no overflow is flagged.
  - Empty: `evt_ready` is ignored.
- `evt_code`/`evt_value` show the head entry (first-word fall-through). They hold stable while `evt_valid`=1 and `evt_ready`=0.

## Timing
- Reset (cycle after `clear` is sampled high):
  - `evt_valid`=0, `evt_code`=0, `evt_value`=0, `level`=0, `overflow`=0.
  - FIFO empty, `prev_valid`=0.
  - `clear` mid-operation discards all queued events and has priority over push and pop.
- Latency: `qd` sampled at edge N produces an event visible on `evt_valid`/`evt_code`/`evt_value` after edge N (cycle N+1). `level` updates on the same edge.
- Pop: the handshake at edge M advances the head; the next entry, or `evt_valid`=0, is visible after edge M.
- Throughput: one push and one pop per cycle sustained.
- Wrap-aware pointers: the count distinguishes full (`DEPTH`) from empty (0).

## Test plan
- Reset and level:
  - Stimulus: `clear`=1 for 2 cycles, then `en`=1, `qd`=8'h10.
  - Response: all outputs 0, no event, `level`=0.
  - Then `qd`=8'hC0: RISE (3'b011, value C0) valid the next cycle, `level`=1.
- Hysteresis band:
  - Stimulus: from HIGH, `qd`=8'h80, then 8'h41.
  - Response: no events.
  - Then `qd`=8'h40: FALL (3'b100, value 40).
- Wrap codes:
  - Stimulus: from HIGH, `qd` steps 8'hFE→8'hFF→8'h00.
  - Response: exactly one event, 3'b101 (value 00), `level`=0.
  - Then 8'h00→8'hFF from LOW: 3'b110, `level`=1.
- Enable gap:
  - Stimulus: `qd`=8'hFF, `en`=0 for 1 cycle, then `en`=1 with `qd`=8'h00.
  - Response: no wrap event; FALL only if `level` was HIGH.
- Overflow:
  - Stimulus: `evt_ready`=0; generate 5 events.
  - Response: 4 queued in order; the 5th dropped; `overflow`=1 and stays set.
  - Drain: 4 pops in order, then `evt_valid`=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, `evt_ready`=1, new event in the same cycle.
  - Response: head popped, new event appended, `overflow` unchanged, count remains 4.
  - Then `clear` asserted mid-stream: `evt_valid`=0 the next cycle.
